reg_bank: RTL
=============

# reg_bank

Architectural register storage with a write-back scoreboard for the single-issue CPU core. Holds 32 general registers (r0 hardwired to zero), exposes every register on a flat bus that drives the 32-input operand-select multiplexers directly, and tracks which registers have an outstanding write-back so decode can stall on RAW hazards. Sits between write-back, decode and operand select.

## Interface
Parameters:
- `width`, 32, register data width
- `MAX_PEND`, 31, maximum simultaneously pending destinations; 31 means no limit below the register count

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous and active-high
- `issue_valid`  in  1  decode issues an instruction that writes `issue_rd`
- `issue_rd`  in  5  destination register of issued instruction
- `issue_ready`  out  1  issue accepted this cycle
- `wb_valid`  in  1  write-back data present
- `wb_rd`  in  5  write-back destination
- `wb_data`  in  width  write-back value
- `rs1`, `rs2`  in  5  decode source registers
- `hazard`  out  1  rs1 or rs2 is busy (r0 never busy)
- `regs_flat`  out  32*width  register contents; slice k = r k
- `busy_vec`  out  32  per-register pending flag
- `pend_cnt`  out  6  count of set bits in `busy_vec`
- `wb_err`  out  1  one-cycle pulse: write-back to a non-busy register

## Operation
- Reset: all registers 0, `busy_vec` 0, `pend_cnt` 0, `wb_err` 0. Reset mid-operation discards all pending state, regardless of concurrent `issue_valid`/`wb_valid`.
- Write-back, `wb_valid`=1 and `wb_rd`≠0: register `wb_rd` ← `wb_data`; busy bit cleared; `pend_cnt` decremented if the bit was set.
- `wb_rd`=0: ignored entirely (no write, no error).
- Write-back to a non-busy register still writes the data; `wb_err`=1 on the next cycle.
- Issue: `issue_ready` = !(`pend_cnt` ≥ `MAX_PEND` && no write-back clears a busy bit this cycle). On `issue_valid`&&`issue_ready` with `issue_rd`≠0: busy bit set, `pend_cnt`+1. `issue_rd`=0: accepted, no state change.
- Issue to an already-busy register (WAW): accepted; bit stays set; count unchanged.
- Simultaneous issue and write-back to the same register: data written, busy bit remains set (new owner pending), count unchanged.
- Simultaneous issue and write-back to different registers: both applied; count net 0.
- `hazard` = (rs1≠0 && busy[rs1]) || (rs2≠0 && busy[rs2]), combinational from current `busy_vec`; no forwarding of same-cycle write-backs.
- `pend_cnt` always equals popcount(`busy_vec`); saturates neither way (invariant guarantees range 0..31).

## Timing
- Write-back latency: data visible on `regs_flat` one cycle after the edge on which `wb_valid` is sampled.
- Busy set/clear visible on `busy_vec`/`hazard` the cycle after the accepting edge.
- `issue_ready`, `hazard`: combinational, same cycle.
- `wb_err`: registered, asserted exactly one cycle after the offending write-back, low otherwise.
- No internal FSM beyond register/scoreboard state; zero-bubble throughput: one issue and one write-back per cycle.

## Structure
- Shared package `cpu_pkg`: `REG_COUNT`=32, `REG_ADDR_W`=5, `reg_addr_t` typedef.
- Sub-module `busy_scoreboard`: busy vector, counter, `issue_ready`, `hazard`, `wb_err`; `reg_bank` instantiates it plus the 31-entry data array.

## Test plan
- Reset then read: `rst`=1 one cycle -> all `regs_flat` slices 0, `busy_vec`=0, `pend_cnt`=0, `issue_ready`=1.
- Issue r5, then wb r5=32'hDEADBEEF two cycles later, rs1=5 throughout -> `hazard`=1 for 2 cycles, then 0; slice 5 = DEADBEEF; `pend_cnt` 0→1→0.
- Same-cycle issue r7 and wb r7=32'h1234 (r7 busy) -> slice 7 = 1234, busy[7] stays 1, `pend_cnt` unchanged.
- wb r0=32'hFFFF_FFFF and issue r0 -> slice 0 stays 0, `busy_vec` unchanged, no `wb_err`.
- wb r9=32'h55 with r9 idle -> slice 9 = 55, `wb_err`=1 for exactly one cycle.
- `MAX_PEND`=2: issue r1, r2, then r3 -> `issue_ready`=0 for r3; with concurrent wb r1, r3 accepted, `pend_cnt` stays 2; assert `rst` mid-sequence -> all cleared next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register file geometry and the register address type.
package cpu_pkg;

   localparam int unsigned REG_COUNT  = 32;
   localparam int unsigned REG_ADDR_W = 5;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   function automatic logic [5:0] popcount(input logic [REG_COUNT-1:0] v);
      logic [5:0] c;
      c = '0;
      for (int i = 0; i < REG_COUNT; i++) begin
         c = c + 6'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/busy_scoreboard.sv
// Write-back scoreboard: per-register pending bits, pending count, issue throttle,
// RAW hazard detect and a one-cycle error pulse for unexpected write-backs.
module busy_scoreboard
   import cpu_pkg::*;
#(
   parameter int unsigned MAX_PEND = 31
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 issue_valid,
   input  reg_addr_t            issue_rd,
   output logic                 issue_ready,
   input  logic                 wb_valid,
   input  reg_addr_t            wb_rd,
   input  reg_addr_t            rs1,
   input  reg_addr_t            rs2,
   output logic                 hazard,
   output logic [REG_COUNT-1:0] busy_vec,
   output logic [5:0]           pend_cnt,
   output logic                 wb_err
);

   logic [REG_COUNT-1:0] busy_q, busy_d;
   logic [5:0]           cnt_q, cnt_d;
   logic                 wb_err_q, wb_err_d;
   logic                 wb_act, wb_clears, issue_act;

   always_comb begin
      wb_act      = wb_valid && (wb_rd != '0);
      wb_clears   = wb_act && busy_q[wb_rd];
      // A write-back freeing a slot this cycle lets a full scoreboard accept an issue.
      issue_ready = !((32'(cnt_q) >= MAX_PEND) && !wb_clears);
      issue_act   = issue_valid && issue_ready && (issue_rd != '0);

      busy_d = busy_q;
      if (wb_act) begin
         busy_d[wb_rd] = 1'b0;
      end
      if (issue_act) begin
         busy_d[issue_rd] = 1'b1;
      end
      cnt_d    = popcount(busy_d);
      wb_err_d = wb_act && !busy_q[wb_rd];

      hazard = ((rs1 != '0) && busy_q[rs1]) || ((rs2 != '0) && busy_q[rs2]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q   <= '0;
         cnt_q    <= '0;
         wb_err_q <= 1'b0;
      end else begin
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         wb_err_q <= wb_err_d;
      end
   end

   assign busy_vec = busy_q;
   assign pend_cnt = cnt_q;
   assign wb_err   = wb_err_q;

endmodule

// File: rtl/reg_bank.sv
// Architectural register file (r0 hardwired to zero) with a flat read bus and
// write-back scoreboard for decode-stage RAW stalls.
module reg_bank
   import cpu_pkg::*;
#(
   parameter int unsigned width    = 32,
   parameter int unsigned MAX_PEND = 31
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       issue_valid,
   input  reg_addr_t                  issue_rd,
   output logic                       issue_ready,
   input  logic                       wb_valid,
   input  reg_addr_t                  wb_rd,
   input  logic [width-1:0]           wb_data,
   input  reg_addr_t                  rs1,
   input  reg_addr_t                  rs2,
   output logic                       hazard,
   output logic [REG_COUNT*width-1:0] regs_flat,
   output logic [REG_COUNT-1:0]       busy_vec,
   output logic [5:0]                 pend_cnt,
   output logic                       wb_err
);

   logic [width-1:0] regs_q [REG_COUNT-1:1];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 1; k < REG_COUNT; k++) begin
            regs_q[k] <= '0;
         end
      end else if (wb_valid && (wb_rd != '0)) begin
         regs_q[wb_rd] <= wb_data;
      end
   end

   always_comb begin
      regs_flat = '0;
      for (int k = 1; k < REG_COUNT; k++) begin
         regs_flat[k*width +: width] = regs_q[k];
      end
   end

   busy_scoreboard #(
      .MAX_PEND (MAX_PEND)
   ) u_busy_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .issue_ready (issue_ready),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .rs1         (rs1),
      .rs2         (rs2),
      .hazard      (hazard),
      .busy_vec    (busy_vec),
      .pend_cnt    (pend_cnt),
      .wb_err      (wb_err)
   );

endmodule
